hdmi_roi_crop: RTL and testbench
================================

# hdmi_roi_crop

Downstream stage of the HDMI loop-through register. It takes the registered 24-bit RGB video with vs/hs/de in the pixel clock domain and cuts out a fixed rectangular region of interest, optionally decimated by 2 in both axes. It emits that region as an RGB565 pixel stream with start-of-frame, end-of-line and end-of-frame markers for the recognition/buffer stage. It also measures the incoming active resolution and flags whether it matches the expected 1080p format.

## Interface
- X_WIDTH, 12, width of the x counter and of the h_meas port
- Y_WIDTH, 12, width of the y counter and of the v_meas port
- X_START, 12'd640, first active column of the ROI (0-based)
- Y_START, 12'd300, first active line of the ROI (0-based)
- ROI_W, 12'd640, ROI width in input pixels
- ROI_H, 12'd480, ROI height in input lines
- DECIM, 1'b0, 0 = every pixel; 1 = keep even ROI-relative columns and rows only
- H_EXP, 12'd1920, expected active width
- V_EXP, 12'd1080, expected active height
- pix_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- crop_en  in  1  frame-atomic enable, sampled only at a vs rising edge
- vs_in, hs_in, de_in  in  1 each  video sync and data enable; vs is positive polarity
- r_in, g_in, b_in  in  8 each  pixel colour components
- pix_valid  out  1  output pixel strobe
- pix_data  out  16  RGB565 pixel: {r[7:3], g[7:2], b[7:3]}
- sof  out  1  high with the first output pixel of a frame
- eol  out  1  high with the last output pixel of each ROI line
- eof  out  1  high with the last output pixel of the ROI
- h_meas  out  X_WIDTH  de-high count of the last completed line
- v_meas  out  Y_WIDTH  number of lines containing de in the last completed frame
- fmt_ok  out  1  high when h_meas == H_EXP and v_meas == V_EXP

## Operation
- **Edge detection:** delayed copies of vs_in and de_in give `vs_rise` and `de_fall`.
- **Counters:**
  - x counts de-high cycles within a line and clears on `de_fall`.
  - y counts lines that contained de. It increments on `de_fall` and clears on `vs_rise`.
  - Both counters saturate at their all-ones value and never wrap.
- **Measurement:**
  - On `de_fall`, h_meas takes the final x count.
  - On `vs_rise`, v_meas takes the y count, and fmt_ok is recomputed from the updated values.
  - Measurement runs in every state.
- **State machine:**
  - S_WAIT: entered on reset. On `vs_rise` with crop_en=1, go to S_RUN; otherwise stay.
  - S_RUN: on `vs_rise` with crop_en=0, go to S_WAIT; otherwise stay.
  - Output is produced only in S_RUN. A partial frame after reset or enable is never emitted.
- **Window:**
  - A pixel is inside when de_in=1, X_START ≤ x < X_START+ROI_W and Y_START ≤ y < Y_START+ROI_H.
  - With DECIM=1, the pixel is also required to satisfy (x−X_START)[0]=0 and (y−Y_START)[0]=0.
- **Markers:**
  - sof: first kept pixel, at (X_START, Y_START).
  - eol: last kept column of each kept row: X_START+ROI_W−1, or X_START+ROI_W−2 when DECIM=1 and ROI_W is even.
  - eof: eol on the last kept row.
  - Markers are qualified by pix_valid.
- **Boundaries:**
  - If the input frame is shorter or narrower than the ROI, the pixels that fall inside are emitted and the missing eol/eof markers are not generated.
  - A vs_rise mid-line clears x and y immediately.
  - The ROI parameters must satisfy X_START+ROI_W ≤ 2^X_WIDTH and Y_START+ROI_H ≤ 2^Y_WIDTH.

## Timing
- **Reset values:**
  - pix_valid, sof, eol, eof, fmt_ok = 0; pix_data = 0; h_meas = 0; v_meas = 0.
  - State = S_WAIT; counters = 0.
- **Latency:** 2 pix_clk cycles from an input pixel sample (de_in=1) to its pix_valid/pix_data.
- **Marker timing:** markers are asserted in the same cycle as their pixel.
- **Handshake:** there is no backpressure; the consumer accepts on every pix_valid.
- **Outside the window:** pix_valid=0, and pix_data holds its last value.
- **State changes:**
  - Take effect for pixels sampled after the vs_rise cycle.
  - crop_en changes between vs edges have no effect.
- **Measurement updates:** h_meas, v_meas and fmt_ok update 1 cycle after the triggering edge is detected.
- **Simultaneous vs_rise and de_fall:** vs_rise wins for y (y=0); h_meas still captures x.

## Test plan
- **1080p nominal.** Defaults, crop_en=1, two frames, constant r=8'h80 g=8'h40 b=8'h20.
  - Frame 1: no output.
  - Frame 2: exactly 307200 pix_valid, all with pix_data=16'h8204.
  - sof once, at the input pixel (640, 300); eol 480 times; eof once.
  - h_meas=1920, v_meas=1080, fmt_ok=1.
- **Decimation.** DECIM=1, x-ramp data.
  - 76800 valid pixels, 240 eol, 320 pixels per line.
  - Pixels only from even relative columns and rows; last column of each line is 1278.
- **Enable control.** crop_en drops mid-frame N.
  - Frame N completes in full, including eof; frame N+1 produces zero pix_valid.
  - crop_en re-raised mid-frame N+1 gives output starting from frame N+2.
- **Reset mid-operation.** rst pulsed during ROI line 100.
  - Outputs go to their reset values the next cycle.
  - No output for the rest of that frame; the next full frame is emitted normally.
- **Short frame.** 720p input (1280x720), default ROI.
  - 420 rows × 640 pixels emitted; no eof.
  - h_meas=1280, v_meas=720, fmt_ok=0.
- **Latency and edges.** Single de pixel at (640, 300).
  - pix_valid exactly 2 cycles later.
  - vs_rise coinciding with de_fall gives y=0 and h_meas updated.

Source files
------------

// File: rtl/hdmi_roi_crop.sv
// rtl/hdmi_roi_crop.sv - ROI crop with optional 2x decimation to an RGB565 stream, plus active-size measurement

module hdmi_roi_crop #(
    parameter int                 X_WIDTH = 12,
    parameter int                 Y_WIDTH = 12,
    parameter logic [X_WIDTH-1:0] X_START = 12'd640,
    parameter logic [Y_WIDTH-1:0] Y_START = 12'd300,
    parameter logic [X_WIDTH-1:0] ROI_W   = 12'd640,
    parameter logic [Y_WIDTH-1:0] ROI_H   = 12'd480,
    parameter logic               DECIM   = 1'b0,
    parameter logic [X_WIDTH-1:0] H_EXP   = 12'd1920,
    parameter logic [Y_WIDTH-1:0] V_EXP   = 12'd1080
) (
    input  logic               pix_clk,
    input  logic               rst,
    input  logic               crop_en,
    input  logic               vs_in,
    input  logic               hs_in,
    input  logic               de_in,
    input  logic [7:0]         r_in,
    input  logic [7:0]         g_in,
    input  logic [7:0]         b_in,
    output logic               pix_valid,
    output logic [15:0]        pix_data,
    output logic               sof,
    output logic               eol,
    output logic               eof,
    output logic [X_WIDTH-1:0] h_meas,
    output logic [Y_WIDTH-1:0] v_meas,
    output logic               fmt_ok
);

    // End bounds carry one extra bit so a ROI touching the counter limit still compares correctly
    localparam logic [X_WIDTH:0] X_END = {1'b0, X_START} + {1'b0, ROI_W};
    localparam logic [Y_WIDTH:0] Y_END = {1'b0, Y_START} + {1'b0, ROI_H};
    localparam logic [X_WIDTH:0] X_LAST_W = (DECIM && !ROI_W[0]) ? X_END - (X_WIDTH+1)'(2)
                                                                 : X_END - (X_WIDTH+1)'(1);
    localparam logic [Y_WIDTH:0] Y_LAST_W = (DECIM && !ROI_H[0]) ? Y_END - (Y_WIDTH+1)'(2)
                                                                 : Y_END - (Y_WIDTH+1)'(1);
    localparam logic [X_WIDTH-1:0] X_LAST = X_LAST_W[X_WIDTH-1:0];
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_LAST_W[Y_WIDTH-1:0];
    localparam logic [X_WIDTH-1:0] X_MAX  = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX  = '1;
    localparam logic [X_WIDTH-1:0] X_ONE  = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE  = Y_WIDTH'(1);

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               vs_d;
    logic               vs_d2;
    logic               de_d;
    logic               de_d2;
    logic [15:0]        pix_d;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;

    logic               vs_rise;
    logic               de_fall;
    logic               in_x;
    logic               in_y;
    logic               on_grid;
    logic               keep;
    logic               sof_hit;
    logic               eol_hit;
    logic               eof_hit;
    logic [X_WIDTH-1:0] h_upd;
    logic               unused_ok;

    assign unused_ok = &{1'b0, hs_in, r_in[2:0], g_in[1:0], b_in[2:0]};

    // x and y index the pixel currently held in the first register stage
    assign vs_rise = vs_d & ~vs_d2;
    assign de_fall = de_d2 & ~de_d;
    assign in_x    = (x >= X_START) && ({1'b0, x} < X_END);
    assign in_y    = (y >= Y_START) && ({1'b0, y} < Y_END);
    assign on_grid = !DECIM || ((x[0] == X_START[0]) && (y[0] == Y_START[0]));
    assign keep    = (state_q == S_RUN) && de_d && in_x && in_y && on_grid;
    assign sof_hit = (x == X_START) && (y == Y_START);
    assign eol_hit = (x == X_LAST);
    assign eof_hit = eol_hit && (y == Y_LAST);
    assign h_upd   = de_fall ? x : h_meas;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (vs_rise && crop_en)  state_d = S_RUN;
            S_RUN:   if (vs_rise && !crop_en) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            vs_d      <= 1'b0;
            vs_d2     <= 1'b0;
            de_d      <= 1'b0;
            de_d2     <= 1'b0;
            pix_d     <= '0;
            x         <= '0;
            y         <= '0;
            h_meas    <= '0;
            v_meas    <= '0;
            fmt_ok    <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            vs_d  <= vs_in;
            vs_d2 <= vs_d;
            de_d  <= de_in;
            de_d2 <= de_d;
            pix_d <= {r_in[7:3], g_in[7:2], b_in[7:3]};

            if (vs_rise || de_fall) begin
                x <= '0;
            end else if (de_d && (x != X_MAX)) begin
                x <= x + X_ONE;
            end

            // vs_rise has priority so a line ending on the vsync edge is not counted into the new frame
            if (vs_rise) begin
                y <= '0;
            end else if (de_fall && (y != Y_MAX)) begin
                y <= y + Y_ONE;
            end

            if (de_fall) begin
                h_meas <= x;
            end
            if (vs_rise) begin
                v_meas <= y;
                fmt_ok <= (h_upd == H_EXP) && (y == V_EXP);
            end

            pix_valid <= keep;
            sof       <= keep && sof_hit;
            eol       <= keep && eol_hit;
            eof       <= keep && eof_hit;
            if (keep) begin
                pix_data <= pix_d;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_roi_crop.sv
// tb/tb_hdmi_roi_crop.sv - directed bench for hdmi_roi_crop on a reduced 10x6 raster with a 4x4 ROI at (3,2)

module tb_hdmi_roi_crop;

    logic       clk = 1'b0;
    logic       rst;
    logic       crop_en;
    logic       vs_in;
    logic       hs_in;
    logic       de_in;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;

    logic        v0, sof0, eol0, eof0, fo0;
    logic [15:0] pd0;
    logic [11:0] hm0, vm0;
    logic        v1, sof1, eol1, eof1, fo1;
    logic [15:0] pd1;
    logic [11:0] hm1, vm1;

    logic [18:0] q0[$];
    logic [18:0] q1[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hdmi_roi_crop #(
        .X_WIDTH(12), .Y_WIDTH(12),
        .X_START(12'd3), .Y_START(12'd2), .ROI_W(12'd4), .ROI_H(12'd4),
        .DECIM(1'b0), .H_EXP(12'd10), .V_EXP(12'd6)
    ) dut_full (
        .pix_clk(clk), .rst(rst), .crop_en(crop_en),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(v0), .pix_data(pd0), .sof(sof0), .eol(eol0), .eof(eof0),
        .h_meas(hm0), .v_meas(vm0), .fmt_ok(fo0)
    );

    hdmi_roi_crop #(
        .X_WIDTH(12), .Y_WIDTH(12),
        .X_START(12'd3), .Y_START(12'd2), .ROI_W(12'd4), .ROI_H(12'd4),
        .DECIM(1'b1), .H_EXP(12'd10), .V_EXP(12'd6)
    ) dut_decim (
        .pix_clk(clk), .rst(rst), .crop_en(crop_en),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(v1), .pix_data(pd1), .sof(sof1), .eol(eol1), .eof(eof1),
        .h_meas(hm1), .v_meas(vm1), .fmt_ok(fo1)
    );

    always @(negedge clk) begin
        if (v0) q0.push_back({sof0, eol0, eof0, pd0});
        if (v1) q1.push_back({sof1, eol1, eof1, pd1});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int xx, input int yy);
        logic [31:0] xv;
        logic [31:0] yv;
        xv = xx;
        yv = yy;
        return {xv[4:0], yv[5:0], 5'b00100};
    endfunction

    task automatic idle(input int n);
        de_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pix(input int xx, input int yy);
        logic [31:0] xv;
        logic [31:0] yv;
        xv    = xx;
        yv    = yy;
        de_in = 1'b1;
        r_in  = {xv[4:0], 3'b101};
        g_in  = {yv[5:0], 2'b11};
        b_in  = 8'h27;
    endtask

    task automatic vs_pulse();
        vs_in = 1'b1;
        idle(2);
        vs_in = 1'b0;
        idle(3);
    endtask

    task automatic send_frame(input bit lead_vs, input int w, input int h, input int en_line,
                              input bit en_val, input int rst_line, input int rst_col);
        if (lead_vs) begin
            vs_in = 1'b1;
            idle(2);
            vs_in = 1'b0;
            idle(2);
        end
        for (int yy = 0; yy < h; yy++) begin
            if (yy == en_line) crop_en = en_val;
            for (int xx = 0; xx < w; xx++) begin
                drive_pix(xx, yy);
                if (yy == rst_line && xx == rst_col) rst = 1'b1;
                @(negedge clk);
                if (rst) begin
                    check_val("rst_mid_valid", 32'(v0), 32'd0);
                    check_val("rst_mid_data", 32'(pd0), 32'd0);
                    check_val("rst_mid_markers", 32'({sof0, eol0, eof0}), 32'd0);
                    check_val("rst_mid_hmeas", 32'(hm0), 32'd0);
                    check_val("rst_mid_vmeas", 32'(vm0), 32'd0);
                    check_val("rst_mid_fmt", 32'(fo0), 32'd0);
                    rst = 1'b0;
                end
            end
            de_in = 1'b0;
            hs_in = 1'b1;
            @(negedge clk);
            hs_in = 1'b0;
            idle(2);
        end
        idle(3);
    endtask

    // Expected stream for the 4x4 ROI at (3,2): full keeps cols 3..6 rows 2..5, decim keeps cols 3,5 rows 2,4
    task automatic check_out(input string tag, input int sel, input int w, input int h, input int lim);
        logic [18:0] expq[$];
        logic [18:0] got[$];
        bit          dec;
        bit          s, l, f;
        int          n;
        dec = (sel == 1);
        if (dec) got = q1;
        else     got = q0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (xx >= 3 && xx < 7 && yy >= 2 && yy < 6 &&
                    (!dec || ((xx % 2 == 1) && (yy % 2 == 0)))) begin
                    s = (xx == 3) && (yy == 2);
                    l = (xx == (dec ? 5 : 6));
                    f = l && (yy == (dec ? 4 : 5));
                    expq.push_back({s, l, f, exp_pix(xx, yy)});
                end
            end
        end
        if (lim >= 0) begin
            while (expq.size() > lim) void'(expq.pop_back());
        end
        check_val($sformatf("%s_count", tag), 32'(got.size()), 32'(expq.size()));
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_px%0d", tag, i), 32'(got[i]), 32'(expq[i]));
        end
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        crop_en = 1'b0;
        vs_in   = 1'b0;
        hs_in   = 1'b0;
        de_in   = 1'b0;
        r_in    = 8'h00;
        g_in    = 8'h00;
        b_in    = 8'h00;
        repeat (3) @(negedge clk);
        check_val("reset_valid", 32'(v0), 32'd0);
        check_val("reset_data", 32'(pd0), 32'd0);
        check_val("reset_markers", 32'({sof0, eol0, eof0}), 32'd0);
        check_val("reset_hmeas", 32'(hm0), 32'd0);
        check_val("reset_vmeas", 32'(vm0), 32'd0);
        check_val("reset_fmt", 32'(fo0), 32'd0);
        check_val("reset_decim_valid", 32'(v1), 32'd0);
        rst     = 1'b0;
        crop_en = 1'b1;
        idle(2);

        // Partial frame with no vsync edge seen: nothing emitted
        clear_q();
        send_frame(1'b0, 10, 6, -1, 1'b0, -1, -1);
        check_out("f1_full", 0, 10, 6, 0);
        check_out("f1_decim", 1, 10, 6, 0);
        check_val("f1_hmeas", 32'(hm0), 32'd10);

        clear_q();
        send_frame(1'b1, 10, 6, -1, 1'b0, -1, -1);
        check_out("f2_full", 0, 10, 6, -1);
        check_out("f2_decim", 1, 10, 6, -1);
        check_val("f2_hmeas", 32'(hm0), 32'd10);
        check_val("f2_vmeas", 32'(vm0), 32'd6);
        check_val("f2_fmt", 32'(fo0), 32'd1);

        // Enable dropped mid-frame: that frame completes, the next is silent
        clear_q();
        send_frame(1'b1, 10, 6, 3, 1'b0, -1, -1);
        check_out("en_n_full", 0, 10, 6, -1);
        check_out("en_n_decim", 1, 10, 6, -1);
        clear_q();
        send_frame(1'b1, 10, 6, 3, 1'b1, -1, -1);
        check_out("en_n1_full", 0, 10, 6, 0);
        check_out("en_n1_decim", 1, 10, 6, 0);
        clear_q();
        send_frame(1'b1, 10, 6, -1, 1'b0, -1, -1);
        check_out("en_n2_full", 0, 10, 6, -1);

        // Reset while the (4,3) pixel is presented: only ROI row 2 survives
        clear_q();
        send_frame(1'b1, 10, 6, -1, 1'b0, 3, 4);
        check_out("rst_full", 0, 10, 6, 4);
        check_out("rst_decim", 1, 10, 6, 2);
        clear_q();
        send_frame(1'b1, 10, 6, -1, 1'b0, -1, -1);
        check_out("rst_next_full", 0, 10, 6, -1);
        check_out("rst_next_decim", 1, 10, 6, -1);

        // Short and narrow frame: partial ROI, no eol/eof
        clear_q();
        send_frame(1'b1, 5, 4, -1, 1'b0, -1, -1);
        check_out("short_full", 0, 5, 4, -1);
        check_out("short_decim", 1, 5, 4, -1);
        vs_pulse();
        check_val("short_hmeas", 32'(hm0), 32'd5);
        check_val("short_vmeas", 32'(vm0), 32'd4);
        check_val("short_fmt", 32'(fo0), 32'd0);

        // Single ROI pixel at (3,2): visible two cycles after it is driven
        send_frame(1'b0, 10, 2, -1, 1'b0, -1, -1);
        for (int xx = 0; xx < 4; xx++) begin
            drive_pix(xx, 2);
            @(negedge clk);
        end
        de_in = 1'b0;
        check_val("lat_cycle1_valid", 32'(v0), 32'd0);
        @(negedge clk);
        check_val("lat_cycle2_valid", 32'(v0), 32'd1);
        check_val("lat_cycle2_data", 32'(pd0), 32'(exp_pix(3, 2)));
        check_val("lat_cycle2_sof", 32'(sof0), 32'd1);
        check_val("lat_cycle2_decim_valid", 32'(v1), 32'd1);
        idle(3);

        // vs rising on the same cycle de falls: h_meas takes the 7-wide line, y restarts at 0
        for (int xx = 0; xx < 7; xx++) begin
            drive_pix(xx, 3);
            @(negedge clk);
        end
        de_in = 1'b0;
        vs_in = 1'b1;
        idle(2);
        vs_in = 1'b0;
        idle(3);
        check_val("coinc_hmeas", 32'(hm0), 32'd7);
        send_frame(1'b0, 10, 2, -1, 1'b0, -1, -1);
        vs_pulse();
        check_val("coinc_vmeas", 32'(vm0), 32'd2);
        check_val("coinc_hmeas_after", 32'(hm0), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
